// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: ALU (A, priority) vs load unit (B, 2-entry FIFO) with a starvation guard.
// Optional read-operand forwarding from the output register when REG_WB_FWD_EN is defined.
module reg_wb_arbiter #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int STARVE_LIMIT       = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic                                 a_valid_in,
  output logic                                 a_ready_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]         a_rd_in,
  input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] a_data_in,
  input  logic                                 b_valid_in,
  output logic                                 b_ready_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]         b_rd_in,
  input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] b_data_in,
  output logic [REG_MEM_DEPTH_POW-1:0]         rd_out,
  output logic [(1 << REG_DATA_WIDTH_POW)-1:0] data_write_out,
  output logic                                 write_en_out,
  output logic                                 busy_out
`ifdef REG_WB_FWD_EN
  ,
  input  logic [REG_MEM_DEPTH_POW-1:0]         rs1_in,
  input  logic [REG_MEM_DEPTH_POW-1:0]         rs2_in,
  output logic                                 fwd1_hit_out,
  output logic                                 fwd2_hit_out,
  output logic [(1 << REG_DATA_WIDTH_POW)-1:0] fwd1_data_out,
  output logic [(1 << REG_DATA_WIDTH_POW)-1:0] fwd2_data_out
`endif
);

  localparam int         REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
  localparam logic [3:0] LIMIT          = 4'(STARVE_LIMIT);

  logic [REG_MEM_DEPTH_POW-1:0] fifo_rd   [2];
  logic [REG_DATA_WIDTH-1:0]    fifo_data [2];
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   count;
  logic [3:0]                   starve_cnt;

  logic                         fifo_nonempty;
  logic                         fifo_full;
  logic                         force_b;
  logic                         grant_a;
  logic                         grant_b;
  logic                         push;
  logic [REG_MEM_DEPTH_POW-1:0] win_rd;
  logic [REG_DATA_WIDTH-1:0]    win_data;

  always_comb begin
    fifo_nonempty = (count != 2'd0);
    fifo_full     = (count == 2'd2);
    force_b       = fifo_nonempty && (starve_cnt == LIMIT);
    // Readies are gated by reset so the producers see no handshake while it is held.
    grant_a       = rst_n_in && a_valid_in && !force_b;
    grant_b       = fifo_nonempty && !grant_a;
    b_ready_out   = rst_n_in && !fifo_full;
    a_ready_out   = grant_a;
    push          = b_valid_in && b_ready_out;
    if (grant_a) begin
      win_rd   = a_rd_in;
      win_data = a_data_in;
    end else begin
      win_rd   = fifo_rd[rd_ptr];
      win_data = fifo_data[rd_ptr];
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= b_rd_in;
      fifo_data[wr_ptr] <= b_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= !wr_ptr;
      if (grant_b)
        rd_ptr <= !rd_ptr;
      count <= count + 2'(push) - 2'(grant_b);
      if (grant_b || !fifo_nonempty)
        starve_cnt <= '0;
      else if (grant_a && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_out         <= '0;
      data_write_out <= '0;
      write_en_out   <= 1'b0;
    end else if (grant_a || grant_b) begin
      rd_out         <= win_rd;
      data_write_out <= win_data;
      write_en_out   <= (win_rd != '0);
    end else begin
      write_en_out   <= 1'b0;
    end
  end

  assign busy_out = fifo_nonempty || write_en_out;

`ifdef REG_WB_FWD_EN
  always_comb begin
    fwd1_hit_out  = write_en_out && (rd_out == rs1_in) && (rs1_in != '0);
    fwd2_hit_out  = write_en_out && (rd_out == rs2_in) && (rs2_in != '0);
    fwd1_data_out = rst_n_in ? data_write_out : '0;
    fwd2_data_out = rst_n_in ? data_write_out : '0;
  end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: queue-based reference model plus directed literal scenarios.
module tb_reg_wb_arbiter;
  localparam int DW     = 64;
  localparam int AW     = 5;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_rd = '0, b_rd = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, write_en, busy;
  logic [AW-1:0] rd_o;
  logic [DW-1:0] data_o;
`ifdef REG_WB_FWD_EN
  logic [AW-1:0] rs1 = '0, rs2 = '0;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(
    .REG_DATA_WIDTH_POW(6),
    .REG_MEM_DEPTH_POW (AW),
    .STARVE_LIMIT      (STARVE)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .a_valid_in    (a_valid),
    .a_ready_out   (a_ready),
    .a_rd_in       (a_rd),
    .a_data_in     (a_data),
    .b_valid_in    (b_valid),
    .b_ready_out   (b_ready),
    .b_rd_in       (b_rd),
    .b_data_in     (b_data),
    .rd_out        (rd_o),
    .data_write_out(data_o),
    .write_en_out  (write_en),
    .busy_out      (busy)
`ifdef REG_WB_FWD_EN
    ,
    .rs1_in        (rs1),
    .rs2_in        (rs2),
    .fwd1_hit_out  (fwd1_hit),
    .fwd2_hit_out  (fwd2_hit),
    .fwd1_data_out (fwd1_data),
    .fwd2_data_out (fwd2_data)
`endif
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: B buffer as a queue, starvation as a plain count of consecutive A wins.
  typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] data; } entry_t;
  entry_t        m_q[$];
  int            m_starve = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin : model_update
    bit     ne, ga, gb, do_push;
    entry_t e;
    if (!rst_n) begin
      m_q.delete();
      m_starve = 0;
      m_we     = 1'b0;
      m_rd     = '0;
      m_data   = '0;
    end else begin
      ne      = (m_q.size() != 0);
      ga      = a_valid && !(ne && m_starve == STARVE);
      gb      = ne && !ga;
      do_push = b_valid && (m_q.size() < 2);
      if (ga) begin
        m_rd = a_rd; m_data = a_data; m_we = (a_rd != 0);
      end else if (gb) begin
        e = m_q.pop_front();
        m_rd = e.rd; m_data = e.data; m_we = (e.rd != 0);
      end else begin
        m_we = 1'b0;
      end
      if (gb || !ne) m_starve = 0;
      else if (ga && m_starve < STARVE) m_starve++;
      if (do_push) m_q.push_back('{rd: b_rd, data: b_data});
    end
  end

  always @(negedge clk) begin : compare
    bit ne, ga;
    #1;
    if (rst_n) begin
      ne = (m_q.size() != 0);
      ga = a_valid && !(ne && m_starve == STARVE);
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, m_q.size() < 2);
      chk("write_en", write_en, m_we);
      chk("busy", busy, ne || m_we);
      chk("rd_out", rd_o, m_rd);
      chk("data_write", data_o, m_data);
`ifdef REG_WB_FWD_EN
      chk("fwd1_hit", fwd1_hit, m_we && (m_rd == rs1) && (rs1 != 0));
      chk("fwd2_hit", fwd2_hit, m_we && (m_rd == rs2) && (rs2 != 0));
      chk("fwd1_data", fwd1_data, m_data);
      chk("fwd2_data", fwd2_data, m_data);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
  endtask

  initial begin
    logic last_ready;
    // Reset state, with a request pending to show readies are suppressed.
    a_valid = 1'b1; a_rd = 5'd4;
    #12;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_rd_out", rd_o, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; a_valid = 1'b0;
    idle(2);

    // A only
    @(negedge clk); a_valid = 1'b1; a_rd = 5'd5; a_data = 64'hDEAD;
    #2 chk("aonly_ready", a_ready, 1);
    @(negedge clk); a_valid = 1'b0;
    #2 chk("aonly_rd", rd_o, 5);
    chk("aonly_data", data_o, 64'hDEAD);
    chk("aonly_we", write_en, 1);
    @(negedge clk);
    #2 chk("aonly_we_off", write_en, 0);

    // B only: two pushes, written back in order
    @(negedge clk); b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h11;
    #2 chk("bonly_ready0", b_ready, 1);
    @(negedge clk); b_rd = 5'd9; b_data = 64'h22;
    #2 chk("bonly_ready1", b_ready, 1);
    @(negedge clk); b_valid = 1'b0;
    #2 chk("bonly_rd7", rd_o, 7);
    chk("bonly_d11", data_o, 64'h11);
    @(negedge clk);
    #2 chk("bonly_rd9", rd_o, 9);
    chk("bonly_d22", data_o, 64'h22);
    idle(2);

    // Starvation: A every cycle, one B entry pushed in the first cycle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_rd = 5'(10 + i); a_data = 64'(100 + i);
      b_valid = (i == 0); b_rd = 5'd3; b_data = 64'h33;
      #2 chk("starve_a_ready", a_ready, (i == 5) ? 1'b0 : 1'b1);
      if (i == 6) begin
        chk("starve_rd", rd_o, 3);
        chk("starve_data", data_o, 64'h33);
        chk("starve_we", write_en, 1);
      end
    end
    idle(2);

    // x0 drop
    @(negedge clk); a_valid = 1'b1; a_rd = 5'd0; a_data = 64'hFFFF;
    #2 chk("x0_ready", a_ready, 1);
    @(negedge clk); a_valid = 1'b0;
    #2 chk("x0_we", write_en, 0);
    chk("x0_busy", busy, 0);

`ifdef REG_WB_FWD_EN
    @(negedge clk); a_valid = 1'b1; a_rd = 5'd12; a_data = 64'hABC; rs1 = 5'd12; rs2 = 5'd0;
    @(negedge clk); a_valid = 1'b0;
    #2 chk("fwd_hit1", fwd1_hit, 1);
    chk("fwd_data1", fwd1_data, 64'hABC);
    chk("fwd_hit2", fwd2_hit, 0);
`endif

    // Reset mid-operation: fill FIFO while A holds the port, then reset between edges
    @(negedge clk); a_valid = 1'b1; a_rd = 5'd1; a_data = 64'h1;
    b_valid = 1'b1; b_rd = 5'd20; b_data = 64'h20;
    @(negedge clk); b_rd = 5'd21; b_data = 64'h21;
    @(negedge clk); b_valid = 1'b0;
    #2 chk("full_b_ready", b_ready, 0);
    chk("full_we", write_en, 1);
    #1 rst_n = 1'b0;
    #1 chk("midrst_we", write_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_b_ready", b_ready, 0);
    chk("midrst_a_ready", a_ready, 0);
    @(negedge clk); rst_n = 1'b1; a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 chk("postrst_we", write_en, 0);
      chk("postrst_b_ready", b_ready, 1);
    end

    // Randomized traffic; A holds its request until accepted
    last_ready = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!(a_valid && !last_ready)) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        a_data  = {$urandom, $urandom};
      end
      b_valid = ($urandom_range(0, 1) != 0);
      b_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      b_data  = {$urandom, $urandom};
`ifdef REG_WB_FWD_EN
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom);
`endif
      #2 last_ready = a_ready;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
